traffic_conflict_monitor: RTL

- Independent safety checker on the light outputs of the traffic light controller (car lights A, B; pedestrian lights PA, PB).
- Reads the four 2-bit light buses every clock.
- Detects illegal codes, conflicting greens, illegal colour sequences and short yellows; latches the first fault and requests all-flash mode.
- Sits beside the controller at top level; it never drives the controller's lights.

---
 rtl/traffic_conflict_monitor_if.sv | 44 ++++
 rtl/traffic_conflict_monitor.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_conflict_monitor_if.sv
// ---------------------------------------------------------------------------
// traffic_conflict_monitor_if
//
// Purpose:
//    Bundles the light buses watched by the conflict monitor together with
//    the monitor's status outputs, so the controller side and the monitor
//    side connect through one port each.
//
// Signals:
//    A, B        car lights (00 red, 01 yellow, 10 green, 11 illegal)
//    PA, PB      pedestrian lights, same encoding
//    CLR         fault clear request (level)
//    ARMED       monitor is running its checks
//    FAULT       sticky fault flag
//    FAULT_CODE  first fault seen, 0 = none
//    FAULT_SRC   light that caused it (0=A, 1=B, 2=PA, 3=PB)
//    FLASH_REQ   request for yellow-flash mode, mirrors FAULT
//
// Modports:
//    master  side that owns the lights and the clear request
//    slave   the monitor itself
// ---------------------------------------------------------------------------
interface traffic_conflict_monitor_if;
    logic [1:0] A;
    logic [1:0] B;
    logic [1:0] PA;
    logic [1:0] PB;
    logic       CLR;
    logic       ARMED;
    logic       FAULT;
    logic [2:0] FAULT_CODE;
    logic [1:0] FAULT_SRC;
    logic       FLASH_REQ;

    modport master (
        output A, B, PA, PB, CLR,
        input  ARMED, FAULT, FAULT_CODE, FAULT_SRC, FLASH_REQ
    );

    modport slave (
        input  A, B, PA, PB, CLR,
        output ARMED, FAULT, FAULT_CODE, FAULT_SRC, FLASH_REQ
    );
endinterface

// File: rtl/traffic_conflict_monitor.sv
// ---------------------------------------------------------------------------
// traffic_conflict_monitor
//
// Purpose:
//    Independent safety checker sitting beside the traffic light controller.
//    Every clock it samples the four light buses and compares them with the
//    values seen on the previous clock. While armed it flags illegal codes,
//    conflicting greens, illegal colour sequences and short yellows. The
//    first fault is latched (code + source) and yellow-flash is requested
//    until a clear request arrives. It never drives the lights itself.
//
// Ports:
//    CLK   rising-edge clock
//    RST   asynchronous active-high reset
//    bus   traffic_conflict_monitor_if.slave (lights + CLR in, status out)
//
// Fault codes (lowest code wins, then source order A > B > PA > PB):
//    1  a light shows the illegal code 11
//    2  both car lights not red
//    3  pedestrian light not red while the crossed car light is not red
//    4  colour change other than red->green, green->yellow, yellow->red
//    5  yellow->red after fewer than MIN_YELLOW yellow cycles
//    6  car light unchanged for MAX_HOLD cycles (watchdog build only)
//
// Configuration:
//    Define TRAFFIC_MON_WATCHDOG_EN to add the per-car-light hold watchdog
//    (fault code 6). Without it MAX_HOLD has no effect.
// ---------------------------------------------------------------------------
module traffic_conflict_monitor #(
    parameter int MIN_YELLOW = 3,
    parameter int CW         = 8,
    parameter int MAX_HOLD   = 40
) (
    input logic                       CLK,
    input logic                       RST,
    traffic_conflict_monitor_if.slave bus
);

    typedef enum logic [1:0] {
        ST_ARM,
        ST_RUN,
        ST_FAULT
    } state_t;

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] MIN_Y   = CW'(MIN_YELLOW);

    state_t        r_state;
    logic [1:0]    w_cur [4];
    logic [1:0]    r_prev [4];
    logic [CW-1:0] r_ycnt [4];

    logic [3:0]    w_illegal;
    logic [3:0]    w_badTrans;
    logic [3:0]    w_shortYel;

    logic          w_faultValid;
    logic [2:0]    w_faultCode;
    logic [1:0]    w_faultSrc;

    logic          r_armed;
    logic          r_fault;
    logic [2:0]    r_code;
    logic [1:0]    r_src;

    // Index order matches the FAULT_SRC numbering so a set bit position is
    // directly the reported source.
    assign w_cur[0] = bus.A;
    assign w_cur[1] = bus.B;
    assign w_cur[2] = bus.PA;
    assign w_cur[3] = bus.PB;

    assign bus.ARMED      = r_armed;
    assign bus.FAULT      = r_fault;
    assign bus.FLASH_REQ  = r_fault;
    assign bus.FAULT_CODE = r_code;
    assign bus.FAULT_SRC  = r_src;

    // Lowest set bit wins, which gives the A > B > PA > PB source priority.
    function automatic logic [1:0] firstSet(input logic [3:0] v);
        logic [1:0] idx;
        if (v[0])      idx = 2'd0;
        else if (v[1]) idx = 2'd1;
        else if (v[2]) idx = 2'd2;
        else           idx = 2'd3;
        return idx;
    endfunction

    // Holding a colour is always fine; the only moves allowed are one step
    // around the red -> green -> yellow -> red cycle.
    function automatic logic legalStep(input logic [1:0] p, input logic [1:0] c);
        return (p == c) ||
               (p == 2'b00 && c == 2'b10) ||
               (p == 2'b10 && c == 2'b01) ||
               (p == 2'b01 && c == 2'b00);
    endfunction

    // Per-light checks that only depend on one light's own history.
    // A yellow->red change is judged against the count of yellow samples
    // accumulated before this edge.
    always_comb begin
        w_illegal  = '0;
        w_badTrans = '0;
        w_shortYel = '0;
        for (int i = 0; i < 4; i++) begin
            w_illegal[i]  = (w_cur[i] == 2'b11);
            w_badTrans[i] = !legalStep(r_prev[i], w_cur[i]);
            w_shortYel[i] = (r_prev[i] == 2'b01) && (w_cur[i] == 2'b00) &&
                            (r_ycnt[i] < MIN_Y);
        end
    end

`ifdef TRAFFIC_MON_WATCHDOG_EN
    localparam logic [CW-1:0] HOLD_LIM = CW'(MAX_HOLD);

    logic [CW-1:0] r_hold [2];
    logic [CW-1:0] w_holdNext [2];
    logic [1:0]    w_holdHit;

    // The hold counters measure how long each car light has stayed on the
    // same value; the fault fires on the edge the count reaches the limit.
    always_comb begin
        w_holdHit = '0;
        for (int i = 0; i < 2; i++) begin
            w_holdNext[i] = '0;
            if (w_cur[i] == r_prev[i]) begin
                w_holdNext[i] = (r_hold[i] == CNT_MAX) ? r_hold[i] : r_hold[i] + CW'(1);
            end
            w_holdHit[i] = (w_holdNext[i] >= HOLD_LIM);
        end
    end

    // Hold counters run in every state so the watchdog sees the full history
    // as soon as checks become active.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 2; i++) begin
                r_hold[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                r_hold[i] <= w_holdNext[i];
            end
        end
    end
`endif

    // Fault arbitration: the chain is written in ascending code order so the
    // first matching branch is always the lowest code present.
    always_comb begin
        w_faultValid = 1'b0;
        w_faultCode  = 3'd0;
        w_faultSrc   = 2'd0;
        if (|w_illegal) begin
            w_faultValid = 1'b1;
            w_faultCode  = 3'd1;
            w_faultSrc   = firstSet(w_illegal);
        end else if (bus.A != 2'b00 && bus.B != 2'b00) begin
            w_faultValid = 1'b1;
            w_faultCode  = 3'd2;
            w_faultSrc   = 2'd0;
        end else if (bus.PA != 2'b00 && bus.A != 2'b00) begin
            w_faultValid = 1'b1;
            w_faultCode  = 3'd3;
            w_faultSrc   = 2'd2;
        end else if (bus.PB != 2'b00 && bus.B != 2'b00) begin
            w_faultValid = 1'b1;
            w_faultCode  = 3'd3;
            w_faultSrc   = 2'd3;
        end else if (|w_badTrans) begin
            w_faultValid = 1'b1;
            w_faultCode  = 3'd4;
            w_faultSrc   = firstSet(w_badTrans);
        end else if (|w_shortYel) begin
            w_faultValid = 1'b1;
            w_faultCode  = 3'd5;
            w_faultSrc   = firstSet(w_shortYel);
`ifdef TRAFFIC_MON_WATCHDOG_EN
        end else if (|w_holdHit) begin
            w_faultValid = 1'b1;
            w_faultCode  = 3'd6;
            w_faultSrc   = w_holdHit[0] ? 2'd0 : 2'd1;
`endif
        end
    end

    // Main monitor FSM plus the history registers. Previous values and yellow
    // counters track the lights in every state; only RUN acts on the checks.
    // Status outputs are updated together with the state so they always
    // describe the state being entered.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_ARM;
            r_armed <= 1'b0;
            r_fault <= 1'b0;
            r_code  <= 3'd0;
            r_src   <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                r_prev[i] <= 2'b00;
                r_ycnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                r_prev[i] <= w_cur[i];
                if (w_cur[i] == 2'b01) begin
                    r_ycnt[i] <= (r_ycnt[i] == CNT_MAX) ? r_ycnt[i] : r_ycnt[i] + CW'(1);
                end else begin
                    r_ycnt[i] <= '0;
                end
            end

            case (r_state)
                ST_ARM: begin
                    if (bus.A == 2'b00 && bus.B == 2'b00 &&
                        bus.PA == 2'b00 && bus.PB == 2'b00) begin
                        r_state <= ST_RUN;
                        r_armed <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_faultValid) begin
                        r_state <= ST_FAULT;
                        r_armed <= 1'b0;
                        r_fault <= 1'b1;
                        r_code  <= w_faultCode;
                        r_src   <= w_faultSrc;
                    end
                end
                ST_FAULT: begin
                    if (bus.CLR) begin
                        r_state <= ST_ARM;
                        r_fault <= 1'b0;
                        r_code  <= 3'd0;
                        r_src   <= 2'd0;
                    end
                end
                default: begin
                    r_state <= ST_ARM;
                    r_armed <= 1'b0;
                    r_fault <= 1'b0;
                    r_code  <= 3'd0;
                    r_src   <= 2'd0;
                end
            endcase
        end
    end

endmodule
